sensor_seq_detector: RTL and testbench

//  Converts two photocell beam sensors at the queue gate into single-cycle
//  inc/dec pulses for the downstream queue people counter.
//  - Sensor A is on the street side; sensor B is on the queue side.
//  - A full A->AB->B->clear sequence is one entry (inc).
//  - A full B->AB->A->clear sequence is one exit (dec).
//  Raw sensors are asynchronous; this block synchronises, debounces and

---
 rtl/sbqm_pkg.sv | 99 +++++++++
 rtl/sensor_seq_detector_if.sv | 14 +
 rtl/sensor_debounce.sv | 39 +++
 rtl/sensor_seq_detector.sv | 87 ++++++++
 tb/tb_sensor_seq_detector.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/sbqm_pkg.sv
// Shared types for the queue-gate beam sequence detector: FSM states, sensor
// codes and the pure transition function used by the top-level FSM register.
package sbqm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        A_IN,
        AB_IN,
        B_IN,
        B_OUT,
        AB_OUT,
        A_OUT,
        WAIT_CLR
    } state_t;

    localparam logic [1:0] S_NONE = 2'b00;
    localparam logic [1:0] S_B    = 2'b01;
    localparam logic [1:0] S_A    = 2'b10;
    localparam logic [1:0] S_BOTH = 2'b11;

    typedef struct packed {
        state_t nxt;
        logic   inc;
        logic   dec;
        logic   err;
    } step_t;

    // Next state and pulse request for code s={a_d,b_d}; anything not listed stays.
    function automatic step_t fsm_step(input state_t cur, input logic [1:0] s);
        step_t r;
        r.nxt = cur;
        r.inc = 1'b0;
        r.dec = 1'b0;
        r.err = 1'b0;
        case (cur)
            IDLE: begin
                case (s)
                    S_A:     r.nxt = A_IN;
                    S_B:     r.nxt = B_OUT;
                    S_BOTH:  begin r.nxt = WAIT_CLR; r.err = 1'b1; end
                    default: r.nxt = IDLE;
                endcase
            end
            A_IN: begin
                case (s)
                    S_BOTH:  r.nxt = AB_IN;
                    S_NONE:  r.nxt = IDLE;
                    S_B:     begin r.nxt = WAIT_CLR; r.err = 1'b1; end
                    default: r.nxt = A_IN;
                endcase
            end
            AB_IN: begin
                case (s)
                    S_B:     r.nxt = B_IN;
                    S_A:     r.nxt = A_IN;
                    S_NONE:  begin r.nxt = IDLE; r.err = 1'b1; end
                    default: r.nxt = AB_IN;
                endcase
            end
            B_IN: begin
                case (s)
                    S_NONE:  begin r.nxt = IDLE; r.inc = 1'b1; end
                    S_BOTH:  r.nxt = AB_IN;
                    S_A:     begin r.nxt = WAIT_CLR; r.err = 1'b1; end
                    default: r.nxt = B_IN;
                endcase
            end
            B_OUT: begin
                case (s)
                    S_BOTH:  r.nxt = AB_OUT;
                    S_NONE:  r.nxt = IDLE;
                    S_A:     begin r.nxt = WAIT_CLR; r.err = 1'b1; end
                    default: r.nxt = B_OUT;
                endcase
            end
            AB_OUT: begin
                case (s)
                    S_A:     r.nxt = A_OUT;
                    S_B:     r.nxt = B_OUT;
                    S_NONE:  begin r.nxt = IDLE; r.err = 1'b1; end
                    default: r.nxt = AB_OUT;
                endcase
            end
            A_OUT: begin
                case (s)
                    S_NONE:  begin r.nxt = IDLE; r.dec = 1'b1; end
                    S_BOTH:  r.nxt = AB_OUT;
                    S_B:     begin r.nxt = WAIT_CLR; r.err = 1'b1; end
                    default: r.nxt = A_OUT;
                endcase
            end
            default: begin
                if (s == S_NONE) r.nxt = IDLE;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sensor_seq_detector_if.sv
// Beam inputs and counter-side pulses of the gate sequence detector.
interface sensor_seq_detector_if;
    logic sens_a;
    logic sens_b;
    logic inc;
    logic dec;
    logic busy;
    logic err_abort;

    modport master (output sens_a, output sens_b,
                    input inc, input dec, input busy, input err_abort);
    modport slave  (input sens_a, input sens_b,
                    output inc, output dec, output busy, output err_abort);
endinterface

// File: rtl/sensor_debounce.sv
// Synchroniser plus stability filter for one raw beam sensor; level moves
// only after the synchronised input has differed for DEB_CYCLES straight cycles.
module sensor_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   synced;

    assign synced = sync[SYNC_STAGES-1];

    // Down-counter reloads whenever the input agrees with level, so a bounce restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= CNT_LOAD;
            level <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            if (synced == level) begin
                cnt <= CNT_LOAD;
            end else if (cnt == '0) begin
                level <= synced;
                cnt   <= CNT_LOAD;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end
endmodule

// File: rtl/sensor_seq_detector.sv
// Queue-gate beam sequence detector: debounced A/B beams drive an entry/exit
// FSM with a dwell timeout, producing single-cycle inc/dec/err_abort pulses.
//
//   state    | meaning
//   IDLE     | both beams clear, waiting
//   A_IN     | entry started, street beam only
//   AB_IN    | entry in progress, both beams
//   B_IN     | entry finishing, queue beam only
//   B_OUT    | exit started, queue beam only
//   AB_OUT   | exit in progress, both beams
//   A_OUT    | exit finishing, street beam only
//   WAIT_CLR | aborted, waiting for both beams clear
module sensor_seq_detector #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEB_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input logic                  clk,
    input logic                  rst,
    sensor_seq_detector_if.slave bus
);
    import sbqm_pkg::*;

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES);

    logic            a_d;
    logic            b_d;
    logic [1:0]      s;
    state_t          state;
    logic [TO_W-1:0] timer;
    step_t           step;
    logic            timed_out;
    logic            inc_q;
    logic            dec_q;
    logic            err_q;

    sensor_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_deb_a (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.sens_a),
        .level (a_d)
    );

    sensor_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_deb_b (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.sens_b),
        .level (b_d)
    );

    assign s         = {a_d, b_d};
    assign step      = fsm_step(state, s);
    assign timed_out = (state != IDLE) && (state != WAIT_CLR) && (timer == TO_LAST);

    // Timeout wins over any transition seen in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
            inc_q <= 1'b0;
            dec_q <= 1'b0;
            err_q <= 1'b0;
        end else if (timed_out) begin
            state <= WAIT_CLR;
            timer <= '0;
            inc_q <= 1'b0;
            dec_q <= 1'b0;
            err_q <= 1'b1;
        end else begin
            state <= step.nxt;
            inc_q <= step.inc;
            dec_q <= step.dec;
            err_q <= step.err;
            if (state == IDLE || step.nxt != state) begin
                timer <= '0;
            end else if (timer != TO_LAST) begin
                timer <= timer + TO_W'(1);
            end
        end
    end

    assign bus.inc       = inc_q;
    assign bus.dec       = dec_q;
    assign bus.err_abort = err_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_sensor_seq_detector.sv
// Directed bench for the gate sequence detector with SYNC_STAGES=2,
// DEB_CYCLES=4, TIMEOUT_CYCLES=50; raw-edge-to-pulse latency is 7 clocks.
module tb_sensor_seq_detector;
    logic clk = 1'b0;
    logic rst = 1'b1;

    sensor_seq_detector_if bus();

    sensor_seq_detector #(
        .SYNC_STAGES    (2),
        .DEB_CYCLES     (4),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mark  = 0;
    int n_inc, n_dec, n_err, n_busy;
    int inc_cyc, dec_cyc, err_cyc;
    int overlap = 0;
    logic prev_pulse = 1'b0;

    task automatic clear_counts();
        n_inc = 0; n_dec = 0; n_err = 0; n_busy = 0;
        inc_cyc = -1; dec_cyc = -1; err_cyc = -1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            int   np;
            logic any;
            @(posedge clk);
            #1;
            cyc++;
            if (bus.inc === 1'b1)       begin n_inc++; inc_cyc = cyc; end
            if (bus.dec === 1'b1)       begin n_dec++; dec_cyc = cyc; end
            if (bus.err_abort === 1'b1) begin n_err++; err_cyc = cyc; end
            if (bus.busy === 1'b1) n_busy++;
            np  = int'(bus.inc === 1'b1) + int'(bus.dec === 1'b1) + int'(bus.err_abort === 1'b1);
            any = (np != 0);
            if (np > 1) overlap++;
            if (any && prev_pulse) overlap++;
            prev_pulse = any;
        end
    endtask

    task automatic drive(input logic a, input logic b, input int n);
        bus.sens_a = a;
        bus.sens_b = b;
        mark = cyc;
        step(n);
    endtask

    task automatic entry_seq();
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 10);
        drive(1'b0, 1'b1, 10);
        drive(1'b0, 1'b0, 10);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.sens_a = 1'b0;
        bus.sens_b = 1'b0;
        step(3);
        total++; if (bus.inc !== 1'b0) begin bad++; $display("FAIL reset_inc: got %b want 0", bus.inc); end
        total++; if (bus.dec !== 1'b0) begin bad++; $display("FAIL reset_dec: got %b want 0", bus.dec); end
        total++; if (bus.err_abort !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.err_abort); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_entry();
        clear_counts();
        entry_seq();
        total++; if (n_inc != 1) begin bad++; $display("FAIL entry_inc_count: got %0d want 1", n_inc); end
        total++; if (inc_cyc - mark != 7) begin bad++; $display("FAIL entry_inc_latency: got %0d want 7", inc_cyc - mark); end
        total++; if (n_dec != 0 || n_err != 0) begin bad++; $display("FAIL entry_other_pulses: got dec=%0d err=%0d want 0 0", n_dec, n_err); end
    endtask

    task automatic test_exit();
        clear_counts();
        drive(1'b0, 1'b1, 10);
        drive(1'b1, 1'b1, 10);
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b0, 10);
        total++; if (n_dec != 1) begin bad++; $display("FAIL exit_dec_count: got %0d want 1", n_dec); end
        total++; if (dec_cyc - mark != 7) begin bad++; $display("FAIL exit_dec_latency: got %0d want 7", dec_cyc - mark); end
        total++; if (n_inc != 0 || n_err != 0) begin bad++; $display("FAIL exit_other_pulses: got inc=%0d err=%0d want 0 0", n_inc, n_err); end
    endtask

    task automatic test_backout_glitch();
        clear_counts();
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b0, 12);
        total++; if (n_busy != 10) begin bad++; $display("FAIL backout_busy_cycles: got %0d want 10", n_busy); end
        drive(1'b0, 1'b1, 2);
        drive(1'b0, 1'b0, 15);
        total++; if (n_busy != 10) begin bad++; $display("FAIL glitch_busy_cycles: got %0d want 10", n_busy); end
        total++; if (n_inc + n_dec + n_err != 0) begin bad++; $display("FAIL backout_pulses: got inc=%0d dec=%0d err=%0d want 0 0 0", n_inc, n_dec, n_err); end
    endtask

    task automatic test_both_break();
        int t0;
        clear_counts();
        drive(1'b1, 1'b1, 10);
        t0 = mark;
        drive(1'b1, 1'b0, 10);
        drive(1'b0, 1'b0, 10);
        total++; if (n_err != 1) begin bad++; $display("FAIL both_err_count: got %0d want 1", n_err); end
        total++; if (err_cyc - t0 != 7) begin bad++; $display("FAIL both_err_latency: got %0d want 7", err_cyc - t0); end
        total++; if (n_inc != 0 || n_dec != 0) begin bad++; $display("FAIL both_no_count: got inc=%0d dec=%0d want 0 0", n_inc, n_dec); end
        entry_seq();
        total++; if (n_inc != 1) begin bad++; $display("FAIL both_then_entry_inc: got %0d want 1", n_inc); end
        total++; if (n_err != 1) begin bad++; $display("FAIL both_then_entry_err: got %0d want 1", n_err); end
    endtask

    task automatic test_timeout();
        clear_counts();
        drive(1'b1, 1'b0, 60);
        total++; if (n_err != 1) begin bad++; $display("FAIL timeout_err_count: got %0d want 1", n_err); end
        total++; if (err_cyc - mark != 58) begin bad++; $display("FAIL timeout_err_time: got %0d want 58", err_cyc - mark); end
        drive(1'b0, 1'b0, 6);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL timeout_busy_hold: got %b want 1", bus.busy); end
        step(1);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL timeout_busy_drop: got %b want 0", bus.busy); end
        step(5);
        total++; if (n_inc != 0 || n_dec != 0 || n_err != 1) begin bad++; $display("FAIL timeout_pulses: got inc=%0d dec=%0d err=%0d want 0 0 1", n_inc, n_dec, n_err); end
    endtask

    task automatic test_reset_mid();
        clear_counts();
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 10);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", bus.busy); end
        rst = 1'b1;
        bus.sens_a = 1'b0;
        bus.sens_b = 1'b0;
        step(1);
        rst = 1'b0;
        total++; if ({bus.inc, bus.dec, bus.err_abort, bus.busy} !== 4'b0000) begin bad++; $display("FAIL mid_reset_outputs: got %b want 0000", {bus.inc, bus.dec, bus.err_abort, bus.busy}); end
        step(15);
        total++; if (n_inc + n_dec + n_err != 0) begin bad++; $display("FAIL mid_reset_pulses: got inc=%0d dec=%0d err=%0d want 0 0 0", n_inc, n_dec, n_err); end
        entry_seq();
        total++; if (n_inc != 1 || n_dec != 0 || n_err != 0) begin bad++; $display("FAIL mid_reset_entry: got inc=%0d dec=%0d err=%0d want 1 0 0", n_inc, n_dec, n_err); end
    endtask

    task automatic test_exclusive();
        total++; if (overlap != 0) begin bad++; $display("FAIL pulse_exclusive: got %0d overlaps want 0", overlap); end
    endtask

    initial begin
        bus.sens_a = 1'b0;
        bus.sens_b = 1'b0;
        clear_counts();
        test_reset();
        test_entry();
        test_exit();
        test_backout_glitch();
        test_both_break();
        test_timeout();
        test_reset_mid();
        test_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
